// File: rtl/epsilon_scheduler.sv
// Exploration-rate scheduler: tracks episodes from the control unit's new_gen pulse and
// decays epsilon per episode, faster after successful ones, down to a fixed floor.
module epsilon_scheduler #(
  parameter logic [15:0] EPS_INIT    = 16'hE666,
  parameter logic [15:0] EPS_MIN     = 16'h0CCD,
  parameter int unsigned DECAY_SHIFT = 4,
  parameter int unsigned WARMUP      = 2,
  parameter logic [5:0]  GOAL_STATE  = 6'd25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  input  logic        new_gen,
  input  logic [5:0]  state_in,
  output logic [15:0] epsilon,
  output logic        eps_update,
  output logic        at_floor,
  output logic [9:0]  episode_cnt,
  output logic [9:0]  success_cnt,
  output logic [5:0]  steps_last
);

  typedef enum logic [1:0] {StIdle, StWarmup, StDecay, StFloor} state_e;

  state_e      state_q, state_d;
  logic        ng_q;
  logic [15:0] eps_q, eps_d;
  logic        upd_q, upd_d;
  logic [9:0]  ep_cnt_q, ep_cnt_d;
  logic [9:0]  succ_q, succ_d;
  logic [5:0]  steps_last_q, steps_last_d;
  logic [5:0]  step_cnt_q, step_cnt_d;
  logic        goal_q, goal_d;

  logic        ng_edge;
  logic        warm_done;
  logic [15:0] dec_amt;
  logic [15:0] eps_nxt;

  assign ng_edge   = new_gen & ~ng_q;
  assign warm_done = (32'(ep_cnt_q) + 32'd1) >= WARMUP;
  // A goal-reaching episode decays by twice the failure step.
  assign dec_amt   = goal_q ? (eps_q >> (DECAY_SHIFT - 1)) : (eps_q >> DECAY_SHIFT);
  assign eps_nxt   = eps_q - dec_amt;

  always_comb begin
    state_d      = state_q;
    eps_d        = eps_q;
    upd_d        = 1'b0;
    ep_cnt_d     = ep_cnt_q;
    succ_d       = succ_q;
    steps_last_d = steps_last_q;
    step_cnt_d   = step_cnt_q;
    goal_d       = goal_q;

    if (ng_edge) begin
      ep_cnt_d = (ep_cnt_q == 10'h3FF) ? ep_cnt_q : ep_cnt_q + 10'd1;
      if (ep_cnt_q != 10'd0) begin
        steps_last_d = step_cnt_q;
        if (goal_q && succ_q != 10'h3FF) succ_d = succ_q + 10'd1;
      end
      // Clear wins over a same-cycle goal hit; it is picked up next cycle if it persists.
      step_cnt_d = 6'd0;
      goal_d     = 1'b0;

      unique case (state_q)
        StIdle:   state_d = warm_done ? StDecay : StWarmup;
        StWarmup: if (warm_done) state_d = StDecay;
        StDecay: begin
          upd_d = 1'b1;
          if (eps_nxt <= EPS_MIN) begin
            eps_d   = EPS_MIN;
            state_d = StFloor;
          end else begin
            eps_d = eps_nxt;
          end
        end
        StFloor:  state_d = StFloor;
      endcase
    end else begin
      if (step_cnt_q != 6'h3F) step_cnt_d = step_cnt_q + 6'd1;
      if (state_in == GOAL_STATE) goal_d = 1'b1;
    end

    if (restart) begin
      state_d      = StIdle;
      eps_d        = EPS_INIT;
      upd_d        = 1'b0;
      ep_cnt_d     = 10'd0;
      succ_d       = 10'd0;
      steps_last_d = 6'd0;
      step_cnt_d   = 6'd0;
      goal_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      ng_q         <= 1'b0;
      eps_q        <= EPS_INIT;
      upd_q        <= 1'b0;
      ep_cnt_q     <= 10'd0;
      succ_q       <= 10'd0;
      steps_last_q <= 6'd0;
      step_cnt_q   <= 6'd0;
      goal_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ng_q         <= new_gen;
      eps_q        <= eps_d;
      upd_q        <= upd_d;
      ep_cnt_q     <= ep_cnt_d;
      succ_q       <= succ_d;
      steps_last_q <= steps_last_d;
      step_cnt_q   <= step_cnt_d;
      goal_q       <= goal_d;
    end
  end

  assign epsilon     = eps_q;
  assign eps_update  = upd_q;
  assign at_floor    = (state_q == StFloor);
  assign episode_cnt = ep_cnt_q;
  assign success_cnt = succ_q;
  assign steps_last  = steps_last_q;

endmodule

// File: tb/tb_epsilon_scheduler.sv
// Bench for epsilon_scheduler: default instance (a) and a low-init, single-warmup instance (b).
module tb_epsilon_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_a, restart_a, new_gen_a;
  logic [5:0]  state_a;
  logic [15:0] eps_a;
  logic        upd_a, flr_a;
  logic [9:0]  ep_a, succ_a;
  logic [5:0]  steps_a;

  logic        rst_n_b, restart_b, new_gen_b;
  logic [5:0]  state_b;
  logic [15:0] eps_b;
  logic        upd_b, flr_b;
  logic [9:0]  ep_b, succ_b;
  logic [5:0]  steps_b;

  epsilon_scheduler dut_a (
    .clk(clk), .rst_n(rst_n_a), .restart(restart_a), .new_gen(new_gen_a),
    .state_in(state_a), .epsilon(eps_a), .eps_update(upd_a), .at_floor(flr_a),
    .episode_cnt(ep_a), .success_cnt(succ_a), .steps_last(steps_a)
  );

  epsilon_scheduler #(.EPS_INIT(16'h0D00), .WARMUP(1)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .restart(restart_b), .new_gen(new_gen_b),
    .state_in(state_b), .epsilon(eps_b), .eps_update(upd_b), .at_floor(flr_b),
    .episode_cnt(ep_b), .success_cnt(succ_b), .steps_last(steps_b)
  );

  // Layout: eps, eps_update, at_floor, episode_cnt, success_cnt, steps_last.
  typedef struct packed {
    logic [15:0] eps;
    logic        upd;
    logic        flr;
    logic [9:0]  ep;
    logic [9:0]  succ;
    logic [5:0]  steps;
  } obs_t;

  obs_t sb_a[$];
  obs_t sb_b[$];
  obs_t got, exp;
  int   checks = 0;
  int   failures = 0;

  function automatic obs_t mk(logic [15:0] e, logic u, logic f, int ep, int s, int st);
    mk = {e, u, f, 10'(ep), 10'(s), 6'(st)};
  endfunction

  function automatic obs_t obs_a();
    obs_a = {eps_a, upd_a, flr_a, ep_a, succ_a, steps_a};
  endfunction

  function automatic obs_t obs_b();
    obs_b = {eps_b, upd_b, flr_b, ep_b, succ_b, steps_b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic edge_a();
    new_gen_a = 1'b1;
    tick();
    new_gen_a = 1'b0;
  endtask

  task automatic edge_b();
    new_gen_b = 1'b1;
    tick();
    new_gen_b = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_a = 1'b0; restart_a = 1'b0; new_gen_a = 1'b0; state_a = 6'd0;
    rst_n_b = 1'b0; restart_b = 1'b0; new_gen_b = 1'b0; state_b = 6'd0;
    repeat (2) tick();
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    sb_a.push_back(mk(16'hE666, 0, 0, 0, 0, 0));
    sb_b.push_back(mk(16'h0D00, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (upd_a !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle_pulse cycle %0d: eps_update=%b required 0", i, upd_a);
      end
    end
    got = obs_a(); exp = sb_a.pop_front(); checks++;
    if (got !== exp) begin
      failures++; $display("FAIL reset_a: got %h required %h", got, exp);
    end
    got = obs_b(); exp = sb_b.pop_front(); checks++;
    if (got !== exp) begin
      failures++; $display("FAIL reset_b: got %h required %h", got, exp);
    end
  endtask

  task automatic test_warmup();
    sb_a.push_back(mk(16'hE666, 0, 0, 1, 0, 0));
    edge_a();
    got = obs_a(); exp = sb_a.pop_front(); checks++;
    if (got !== exp) begin
      failures++; $display("FAIL warmup_edge1: got %h required %h", got, exp);
    end
    repeat (4) tick();
    sb_a.push_back(mk(16'hE666, 0, 0, 2, 0, 4));
    edge_a();
    got = obs_a(); exp = sb_a.pop_front(); checks++;
    if (got !== exp) begin
      failures++; $display("FAIL warmup_edge2: got %h required %h", got, exp);
    end
  endtask

  task automatic test_decay_success();
    state_a = 6'd25;
    tick();
    state_a = 6'd0;
    repeat (2) tick();
    sb_a.push_back(mk(16'hC99A, 1, 0, 3, 1, 3));
    edge_a();
    got = obs_a(); exp = sb_a.pop_front(); checks++;
    if (got !== exp) begin
      failures++; $display("FAIL decay_success: got %h required %h", got, exp);
    end
    sb_a.push_back(mk(16'hC99A, 0, 0, 3, 1, 3));
    tick();
    got = obs_a(); exp = sb_a.pop_front(); checks++;
    if (got !== exp) begin
      failures++; $display("FAIL pulse_single: got %h required %h", got, exp);
    end
  endtask

  // Goal seen only in the edge cycle belongs to the next episode.
  task automatic test_goal_on_edge();
    repeat (3) tick();
    state_a = 6'd25;
    sb_a.push_back(mk(16'hBD01, 1, 0, 4, 1, 4));
    edge_a();
    got = obs_a(); exp = sb_a.pop_front(); checks++;
    if (got !== exp) begin
      failures++; $display("FAIL goal_on_edge_ending: got %h required %h", got, exp);
    end
    tick();
    state_a = 6'd0;
    repeat (3) tick();
    sb_a.push_back(mk(16'hA561, 1, 0, 5, 2, 4));
    edge_a();
    got = obs_a(); exp = sb_a.pop_front(); checks++;
    if (got !== exp) begin
      failures++; $display("FAIL goal_on_edge_next: got %h required %h", got, exp);
    end
  endtask

  task automatic test_restart_edge();
    repeat (2) tick();
    restart_a = 1'b1;
    new_gen_a = 1'b1;
    sb_a.push_back(mk(16'hE666, 0, 0, 0, 0, 0));
    tick();
    got = obs_a(); exp = sb_a.pop_front(); checks++;
    if (got !== exp) begin
      failures++; $display("FAIL restart_edge: got %h required %h", got, exp);
    end
    restart_a = 1'b0;
    sb_a.push_back(mk(16'hE666, 0, 0, 0, 0, 0));
    tick();
    got = obs_a(); exp = sb_a.pop_front(); checks++;
    if (got !== exp) begin
      failures++; $display("FAIL restart_held_no_edge: got %h required %h", got, exp);
    end
    new_gen_a = 1'b0;
  endtask

  task automatic test_decay_fail();
    tick();
    sb_a.push_back(mk(16'hE666, 0, 0, 1, 0, 0));
    edge_a();
    got = obs_a(); exp = sb_a.pop_front(); checks++;
    if (got !== exp) begin
      failures++; $display("FAIL restart_idle_edge1: got %h required %h", got, exp);
    end
    repeat (4) tick();
    edge_a();
    repeat (4) tick();
    sb_a.push_back(mk(16'hD800, 1, 0, 3, 0, 4));
    edge_a();
    got = obs_a(); exp = sb_a.pop_front(); checks++;
    if (got !== exp) begin
      failures++; $display("FAIL decay_fail: got %h required %h", got, exp);
    end
  endtask

  task automatic test_hold();
    tick();
    new_gen_a = 1'b1;
    sb_a.push_back(mk(16'hCA80, 1, 0, 4, 0, 1));
    tick();
    got = obs_a(); exp = sb_a.pop_front(); checks++;
    if (got !== exp) begin
      failures++; $display("FAIL hold_first: got %h required %h", got, exp);
    end
    sb_a.push_back(mk(16'hCA80, 0, 0, 4, 0, 1));
    repeat (3) tick();
    got = obs_a(); exp = sb_a.pop_front(); checks++;
    if (got !== exp) begin
      failures++; $display("FAIL hold_one_edge: got %h required %h", got, exp);
    end
    new_gen_a = 1'b0;
  endtask

  task automatic test_long_episode();
    repeat (70) tick();
    sb_a.push_back(mk(16'hBDD8, 1, 0, 5, 0, 63));
    edge_a();
    got = obs_a(); exp = sb_a.pop_front(); checks++;
    if (got !== exp) begin
      failures++; $display("FAIL long_episode: got %h required %h", got, exp);
    end
  endtask

  task automatic test_async_reset();
    repeat (3) tick();
    @(posedge clk);
    #3;
    rst_n_a = 1'b0;
    #1;
    sb_a.push_back(mk(16'hE666, 0, 0, 0, 0, 0));
    got = obs_a(); exp = sb_a.pop_front(); checks++;
    if (got !== exp) begin
      failures++; $display("FAIL async_reset_immediate: got %h required %h", got, exp);
    end
    tick();
    rst_n_a = 1'b1;
    tick();
    sb_a.push_back(mk(16'hE666, 0, 0, 0, 0, 0));
    got = obs_a(); exp = sb_a.pop_front(); checks++;
    if (got !== exp) begin
      failures++; $display("FAIL async_reset_release: got %h required %h", got, exp);
    end
  endtask

  task automatic test_floor();
    sb_b.push_back(mk(16'h0D00, 0, 0, 1, 0, 0));
    edge_b();
    got = obs_b(); exp = sb_b.pop_front(); checks++;
    if (got !== exp) begin
      failures++; $display("FAIL floor_first_edge: got %h required %h", got, exp);
    end
    repeat (3) tick();
    sb_b.push_back(mk(16'h0CCD, 1, 1, 2, 0, 3));
    edge_b();
    got = obs_b(); exp = sb_b.pop_front(); checks++;
    if (got !== exp) begin
      failures++; $display("FAIL floor_clamp: got %h required %h", got, exp);
    end
    sb_b.push_back(mk(16'h0CCD, 0, 1, 2, 0, 3));
    tick();
    got = obs_b(); exp = sb_b.pop_front(); checks++;
    if (got !== exp) begin
      failures++; $display("FAIL floor_pulse_end: got %h required %h", got, exp);
    end
    repeat (2) tick();
    sb_b.push_back(mk(16'h0CCD, 0, 1, 3, 0, 3));
    edge_b();
    got = obs_b(); exp = sb_b.pop_front(); checks++;
    if (got !== exp) begin
      failures++; $display("FAIL floor_hold1: got %h required %h", got, exp);
    end
    tick();
    sb_b.push_back(mk(16'h0CCD, 0, 1, 4, 0, 1));
    edge_b();
    got = obs_b(); exp = sb_b.pop_front(); checks++;
    if (got !== exp) begin
      failures++; $display("FAIL floor_hold2: got %h required %h", got, exp);
    end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_decay_success();
    test_goal_on_edge();
    test_restart_edge();
    test_decay_fail();
    test_hold();
    test_long_episode();
    test_async_reset();
    test_floor();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
